// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback controller for the 8-bit ALU.
// Owns the PC, instruction register, accumulator, the r0-r7 register file and
// the {s,p,ov,cy,z} flag register. Each instruction takes four cycles.
//
// Interface timing: there is no valid/ready handshake on either side. Program
// memory is a fixed one-cycle synchronous read: pc_addr is presented in FETCH
// and instr_word is captured in DECODE. The ALU is purely combinational: its
// inputs come from IR/acc/register file and are stable during EXEC, and its
// result and flags are sampled only on the EXEC->WB edge.
module alu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  pc_addr,
   input  logic [13:0] instr_word,
   output logic [5:0]  alu_instr_code,
   output logic [7:0]  alu_in_data,
   output logic [7:0]  alu_reg_file,
   input  logic [7:0]  alu_result,
   input  logic        alu_flag_z,
   input  logic        alu_flag_cy,
   input  logic        alu_flag_ov,
   input  logic        alu_flag_p,
   input  logic        alu_flag_s,
   output logic [4:0]  flags,
   output logic [7:0]  acc,
   output logic        busy,
   output logic        halted
);

   // Instruction encoding shared with the ALU and the assembler.
   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04;
   localparam logic [5:0] OP_XOR  = 6'h05;
   localparam logic [5:0] OP_NOT  = 6'h06;
   localparam logic [5:0] OP_RR   = 6'h07;
   localparam logic [5:0] OP_RL   = 6'h08;
   localparam logic [5:0] OP_INC  = 6'h09;
   localparam logic [5:0] OP_DEC  = 6'h0A;
   localparam logic [5:0] OP_LDI  = 6'h10;
   localparam logic [5:0] OP_LDR  = 6'h11;
   localparam logic [5:0] OP_MOV  = 6'h12;
   localparam logic [5:0] OP_JMP  = 6'h20;
   localparam logic [5:0] OP_JZ   = 6'h21;
   localparam logic [5:0] OP_JC   = 6'h22;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   state_t      state;
   logic [7:0]  pc;
   logic [13:0] ir;
   logic [7:0]  rf [0:7];
   logic        take_jump;

   logic [5:0]  opcode;
   logic [7:0]  operand;
   logic        is_alu_op;
   logic        jump_cond;

   assign opcode         = ir[13:8];
   assign operand        = ir[7:0];
   assign pc_addr        = pc;
   assign alu_instr_code = opcode;
   assign alu_in_data    = acc;
   assign alu_reg_file   = rf[ir[2:0]];

   // Decode: which opcodes commit the ALU result, and whether a jump fires.
   // Jump conditions use the flag register as it stood before this instruction.
   always_comb begin
      is_alu_op = 1'b0;
      jump_cond = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_NOT, OP_RR, OP_RL, OP_INC, OP_DEC: is_alu_op = 1'b1;
         OP_JMP:                               jump_cond = 1'b1;
         OP_JZ:                                jump_cond = flags[0];
         OP_JC:                                jump_cond = flags[1];
         default: begin
            is_alu_op = 1'b0;
            jump_cond = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with all architectural state and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= 8'h00;
         ir        <= 14'h0000;
         acc       <= 8'h00;
         flags     <= 5'b00000;
         take_jump <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc    <= 8'h00;
                  busy  <= 1'b1;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               ir    <= instr_word;
               state <= S_EXEC;
            end
            S_EXEC: begin
               take_jump <= jump_cond;
               if (is_alu_op) begin
                  acc <= alu_result;
                  // Carry is only architecturally updated by ADD.
                  flags <= {alu_flag_s, alu_flag_p, alu_flag_ov,
                            (opcode == OP_ADD) ? alu_flag_cy : flags[1],
                            alu_flag_z};
               end else if (opcode == OP_LDI) begin
                  acc <= operand;
               end else if (opcode == OP_LDR) begin
                  acc <= rf[operand[2:0]];
               end else if (opcode == OP_MOV) begin
                  rf[operand[2:0]] <= acc;
               end
               if (opcode == OP_HALT) begin
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  state  <= S_HALTED;
               end else begin
                  state <= S_WB;
               end
            end
            S_WB: begin
               pc    <= take_jump ? operand : pc + 8'd1;
               state <= S_FETCH;
            end
            S_HALTED: begin
               if (start) begin
                  pc     <= 8'h00;
                  busy   <= 1'b1;
                  halted <= 1'b0;
                  state  <= S_FETCH;
               end
            end
            default: begin
               busy   <= 1'b0;
               halted <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control sequencer that drives the 8-bit ALU: fetches 14-bit instruction words from synchronous program memory, decodes them, presents opcode and operands to the ALU, and commits the result and flags. Holds the accumulator, an 8×8 register file, the program counter and the flag register. Resolves flag-conditional jumps, so it is the issuing side of the ALU interface.

## Interface
Parameters:
- none. Widths are fixed by the ALU: 6-bit opcode, 8-bit data, 8-bit PC.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALTED and begin fetching at PC 0x00; ignored in other states
- pc_addr  out  8  program memory address; registered, equals PC
- instr_word  in  14  program memory data: [13:8] opcode (shared instruction macros), [7:0] operand; valid one cycle after pc_addr
- alu_instr_code  out  6  latched opcode (IR[13:8])
- alu_in_data  out  8  accumulator value
- alu_reg_file  out  8  r[IR[2:0]]
- alu_result  in  8  ALU result, combinational
- alu_flag_z, alu_flag_cy, alu_flag_ov, alu_flag_p, alu_flag_s  in  1 each  ALU flags, combinational
- flags  out  5  {s,p,ov,cy,z} flag register
- acc  out  8  accumulator
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALTED

## Operation
- States: IDLE → FETCH → DECODE → EXEC → WB → FETCH …; HALT executes to HALTED. Every instruction takes exactly 4 cycles.
- IDLE: on start=1, PC←0x00, go to FETCH.
- FETCH: pc_addr=PC is presented; memory returns the word next cycle.
- DECODE: IR←instr_word.
- EXEC: ALU inputs are stable from IR. Commits happen on the EXEC→WB edge:
  - NOT, XOR, OR, AND, SUB, ADD, RR, RL, DEC, INC: acc←alu_result; z, p, s, ov←ALU flags. cy←alu_flag_cy only for ADD; otherwise cy keeps its value.
  - LDI: acc←operand. LDR: acc←r[operand[2:0]]. MOV: r[operand[2:0]]←acc. Flags unchanged.
  - JMP/JZ/JC: jump is taken if (JMP) or (JZ and z=1) or (JC and cy=1), using the flag register before this instruction.
  - NOP and any undefined opcode: no state change.
  - HALT: next state is HALTED instead of WB.
- WB: PC←operand if the jump is taken, else PC+1 modulo 256 (0xFF→0x00, no trap). Go to FETCH.
- HALTED: PC, acc, registers and flags hold. start=1 sets PC←0x00 and goes to FETCH; acc, registers and flags are preserved.
- start is ignored in all other states.
- Reset values: state IDLE, PC 0x00, IR 0, acc 0x00, r0–r7 0x00, flags 0, busy 0, halted 0, pc_addr 0x00, alu_instr_code 0.
- Reset asserted mid-instruction forces all reset values immediately; no partial commit survives.

## Timing
- start sampled at cycle N in IDLE → FETCH at N+1 with pc_addr=0x00; IR valid from N+3 (DECODE edge at N+2).
- Memory read latency is exactly 1 cycle. instr_word is only sampled in DECODE.
- ALU path is combinational: alu_result must settle within the EXEC cycle. The sequencer samples it only on the EXEC→WB edge.
- acc/flags/register updates are visible from the first WB cycle. The new PC is visible from the following FETCH.
- Instruction throughput: 1 per 4 cycles. No pipelining, no hazards.
- busy falls on the same edge that halted rises.

## Test plan
- Reset: drive arbitrary inputs with rst_n=0 → all outputs at their reset values. Hold start=0 after release → stays IDLE, busy=0.
- ADD with carry: program LDI 0xF0; MOV r1; LDI 0x20; ADD r1; HALT → acc=0x10, cy=1, z=0, s=0, p=0. halted=1 after 20 cycles from start.
- cy retention: after the ADD above, execute INC → acc=0x11, cy stays 1. Then XOR with r1=0xF0 → acc=0xE1, s=1, cy=1.
- Conditional jump: LDI 0x01; DEC r0 (z=1); JZ 0x10 → next pc_addr=0x10. Repeat with z=0 → next pc_addr=0x03.
- PC wrap: NOP at 0xFF → next fetch at 0x00. HALT at 0x00 → halted=1. Then start → fetch at 0x00 with acc preserved.
- Reset mid-instruction: assert rst_n=0 during EXEC of an ADD → acc and flags read 0 immediately, state is IDLE, and start restarts from 0x00.
